// File: rtl/sram_arb_pkg.sv
// Shared types and timing defaults for the SRAM arbiter.
// Optional feature macro: SRAM_ARB_RR_EN (round-robin arbitration).
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RD_CYC = 2;
  localparam int DEF_WR_CYC = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } arb_state_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_sel_e;

  // Dwell counter width: it only ever holds (cycles - 1) of the longer phase.
  function automatic int cnt_width(input int rd_cyc, input int wr_cyc);
    int m;
    m = (rd_cyc > wr_cyc) ? rd_cyc : wr_cyc;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signal bundle for the SRAM arbiter.
// slave = the arbiter; master = requesters plus the SRAM/tri-state side.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [1:0]        p1_be;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_ub_n;
  logic              sram_lb_n;
  logic [DATA_W-1:0] data_to_sram;
  logic [DATA_W-1:0] data_from_sram;
  logic              sram_drive;

  modport slave (
    input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, p1_be, data_from_sram,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
    output data_to_sram, sram_drive
  );

  modport master (
    output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, p1_be, data_from_sram,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
    input  data_to_sram, sram_drive
  );
endinterface

// File: rtl/sram_arb_timer.sv
// Loadable down-counter timing the RD and WR_PULSE dwell; o_done when it hits 0.
module sram_arb_timer #(
  parameter int CNT_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Load on phase entry, then count down and park at zero.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for a 16-bit asynchronous SRAM.
// Port 0: VGA line-fetch reads. Port 1: game-logic reads/writes with byte enables.
// Optional macro SRAM_ARB_RR_EN: round-robin on ties; otherwise strict port-0 priority.
// All SRAM strobes are registered; no arbitration happens in the cycle an Ack is high,
// so a requester that keeps Req up through its Ack pulse is not granted twice.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_CYC = DEF_RD_CYC,
  parameter int WR_CYC = DEF_WR_CYC
) (
  input logic           i_clk,
  input logic           i_rst_n,
  sram_arbiter_if.slave bus
);

  localparam int               CNT_W   = cnt_width(RD_CYC, WR_CYC);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYC - 1);

  arb_state_e        r_state;
  port_sel_e         r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_be;
  logic              r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n, r_drive;
  logic              r_p0_ack, r_p1_ack;
  logic [DATA_W-1:0] r_p0_rdata, r_p1_rdata;

  arb_state_e        w_state_nxt;
  port_sel_e         w_sel_nxt;
  port_sel_e         w_grant_sel;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic [1:0]        w_be_nxt;
  logic              w_grant;
  logic              w_grant_fire;
  logic              w_tmr_load;
  logic [CNT_W-1:0]  w_tmr_val;
  logic              w_tmr_done;
  logic              w_rd_capture;
  logic              w_p0_ack_nxt, w_p1_ack_nxt;
  logic              w_in_wr;

  sram_arb_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  assign w_grant = (bus.p0_req | bus.p1_req) & ~(r_p0_ack | r_p1_ack);

`ifdef SRAM_ARB_RR_EN
  port_sel_e r_last;

  // On a tie the port not granted last wins.
  always_comb begin
    if (bus.p0_req && bus.p1_req) begin
      w_grant_sel = (r_last == PORT0) ? PORT1 : PORT0;
    end else begin
      w_grant_sel = bus.p0_req ? PORT0 : PORT1;
    end
  end

  // Remember the last granted port; port 1 after reset so port 0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= PORT1;
    end else if (w_grant_fire) begin
      r_last <= w_grant_sel;
    end
  end
`else
  // Strict priority: the video reader always wins a tie.
  always_comb begin
    w_grant_sel = bus.p0_req ? PORT0 : PORT1;
  end
`endif

  assign w_grant_fire = (r_state == IDLE) && w_grant;

  // Next-state, latched-request and dwell-timer control.
  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_be_nxt     = r_be;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_rd_capture = 1'b0;
    w_p0_ack_nxt = 1'b0;
    w_p1_ack_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_sel_nxt = w_grant_sel;
          if (w_grant_sel == PORT0) begin
            w_addr_nxt  = bus.p0_addr;
            w_be_nxt    = 2'b11;
            w_state_nxt = RD;
            w_tmr_load  = 1'b1;
            w_tmr_val   = RD_LOAD;
          end else begin
            w_addr_nxt  = bus.p1_addr;
            w_wdata_nxt = bus.p1_wdata;
            w_be_nxt    = bus.p1_be;
            if (bus.p1_we) begin
              w_state_nxt = WR_SETUP;
            end else begin
              w_state_nxt = RD;
              w_tmr_load  = 1'b1;
              w_tmr_val   = RD_LOAD;
            end
          end
        end
      end
      RD: begin
        if (w_tmr_done) begin
          w_state_nxt  = IDLE;
          w_rd_capture = 1'b1;
          w_p0_ack_nxt = (r_sel == PORT0);
          w_p1_ack_nxt = (r_sel == PORT1);
        end
      end
      WR_SETUP: begin
        w_state_nxt = WR_PULSE;
        w_tmr_load  = 1'b1;
        w_tmr_val   = WR_LOAD;
      end
      WR_PULSE: begin
        if (w_tmr_done) begin
          w_state_nxt = WR_HOLD;
        end
      end
      WR_HOLD: begin
        w_state_nxt  = IDLE;
        w_p1_ack_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_in_wr = (w_state_nxt == WR_SETUP) || (w_state_nxt == WR_PULSE) ||
                   (w_state_nxt == WR_HOLD);

  // State, latched request, and strobes registered from the next state so they switch together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_sel      <= PORT0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= 2'b00;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_ub_n     <= 1'b1;
      r_lb_n     <= 1'b1;
      r_drive    <= 1'b0;
      r_p0_ack   <= 1'b0;
      r_p1_ack   <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_be     <= w_be_nxt;
      r_ce_n   <= (w_state_nxt == IDLE);
      r_oe_n   <= (w_state_nxt != RD);
      r_we_n   <= (w_state_nxt != WR_PULSE);
      r_ub_n   <= (w_state_nxt == IDLE) || !w_be_nxt[1];
      r_lb_n   <= (w_state_nxt == IDLE) || !w_be_nxt[0];
      r_drive  <= w_in_wr;
      r_p0_ack <= w_p0_ack_nxt;
      r_p1_ack <= w_p1_ack_nxt;
      if (w_rd_capture && (r_sel == PORT0)) begin
        r_p0_rdata <= bus.data_from_sram;
      end
      if (w_rd_capture && (r_sel == PORT1)) begin
        r_p1_rdata <= bus.data_from_sram;
      end
    end
  end

  assign bus.p0_ack       = r_p0_ack;
  assign bus.p0_rdata     = r_p0_rdata;
  assign bus.p1_ack       = r_p1_ack;
  assign bus.p1_rdata     = r_p1_rdata;
  assign bus.sram_addr    = r_addr;
  assign bus.sram_ce_n    = r_ce_n;
  assign bus.sram_oe_n    = r_oe_n;
  assign bus.sram_we_n    = r_we_n;
  assign bus.sram_ub_n    = r_ub_n;
  assign bus.sram_lb_n    = r_lb_n;
  assign bus.data_to_sram = r_wdata;
  assign bus.sram_drive   = r_drive;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed cases plus randomized traffic
// against a word-level reference memory and a transaction-level arbitration model.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int RD_CYC = 2;
  localparam int WR_CYC = 2;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sif ();

  sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_CYC(RD_CYC), .WR_CYC(WR_CYC)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (sif.slave)
  );

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int tb_last = 1;
  logic [15:0] last_p0_rd = 16'h0000;

  logic [15:0] sram_mem [int];
  logic [15:0] ref_mem  [int];

  function automatic logic [15:0] sram_rd(input int a);
    return sram_mem.exists(a) ? sram_mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic [1:0] be);
    return {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
  endfunction

  // Asynchronous SRAM model plus bus-rule monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!sif.sram_ce_n && !sif.sram_we_n) begin
      sram_mem[int'(sif.sram_addr)] = merge(sram_rd(int'(sif.sram_addr)), sif.data_to_sram,
                                            {!sif.sram_ub_n, !sif.sram_lb_n});
    end
    if (!sif.sram_ce_n && !sif.sram_oe_n) sif.data_from_sram = sram_rd(int'(sif.sram_addr));
    else sif.data_from_sram = 16'h0000;
    if (!sif.sram_oe_n && !sif.sram_we_n) viol++;
    if (!sif.sram_oe_n && sif.sram_drive) viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One access from an idle arbiter; checks latency, strobe framing, data, Ack width.
  task automatic access(input int port, input logic we, input logic [19:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be, input string tag);
    int n, oe_cnt, we_cnt, drv_cnt, addr_bad, strobe_bad, f_drv, l_drv, f_we, l_we;
    bit acked;
    logic [15:0] exp_rd, got_rd;
    logic [1:0] exp_bn;
    exp_rd = ref_rd(int'(addr));
    exp_bn = (port == 0) ? 2'b00 : ~be;
    if (port == 0) begin
      sif.p0_req = 1'b1; sif.p0_addr = addr;
    end else begin
      sif.p1_req = 1'b1; sif.p1_we = we; sif.p1_addr = addr; sif.p1_wdata = wdata; sif.p1_be = be;
    end
    n = 0; oe_cnt = 0; we_cnt = 0; drv_cnt = 0; addr_bad = 0; strobe_bad = 0;
    f_drv = -1; l_drv = -1; f_we = -1; l_we = -1; acked = 1'b0;
    while (!acked && n < 40) begin
      @(negedge clk);
      n++;
      if (!sif.sram_oe_n) oe_cnt++;
      if (!sif.sram_we_n) begin we_cnt++; if (f_we < 0) f_we = n; l_we = n; end
      if (sif.sram_drive) begin drv_cnt++; if (f_drv < 0) f_drv = n; l_drv = n; end
      if (!sif.sram_ce_n && sif.sram_addr !== addr) addr_bad++;
      if ((!sif.sram_oe_n || !sif.sram_we_n) && {sif.sram_ub_n, sif.sram_lb_n} !== exp_bn)
        strobe_bad++;
      acked = (port == 0) ? (sif.p0_ack === 1'b1) : (sif.p1_ack === 1'b1);
    end
    got_rd = (port == 0) ? sif.p0_rdata : sif.p1_rdata;
    sif.p0_req = 1'b0;
    sif.p1_req = 1'b0;
    check($sformatf("%s_ack_seen", tag), 32'(acked), 1);
    check($sformatf("%s_latency", tag), n, we ? WR_CYC + 3 : RD_CYC + 1);
    check($sformatf("%s_oe_cycles", tag), oe_cnt, we ? 0 : RD_CYC);
    check($sformatf("%s_we_cycles", tag), we_cnt, we ? WR_CYC : 0);
    check($sformatf("%s_drive_cycles", tag), drv_cnt, we ? WR_CYC + 2 : 0);
    check($sformatf("%s_addr_stable", tag), addr_bad, 0);
    check($sformatf("%s_byte_strobes", tag), strobe_bad, 0);
    if (we) begin
      check($sformatf("%s_wr_frame", tag), {30'd0, f_we == f_drv + 1, l_drv == l_we + 1}, 3);
      ref_mem[int'(addr)] = merge(ref_rd(int'(addr)), wdata, be);
    end else begin
      check($sformatf("%s_rdata", tag), got_rd, exp_rd);
      if (port == 0) last_p0_rd = exp_rd;
    end
    @(negedge clk);
    check($sformatf("%s_ack_pulse", tag),
          32'((port == 0) ? sif.p0_ack : sif.p1_ack), 0);
    tb_last = port;
  endtask

  // Both ports request reads at once; grant order compared with a tie-break model.
  task automatic both_req(input int n, input bit p0_hold, input logic [19:0] a0,
                          input logic [19:0] a1, input string tag);
    int exp_q[$];
    int got_q[$];
    bit pend0, pend1;
    int last, g, cyc, gv;
    pend0 = 1'b1; pend1 = 1'b1; last = tb_last;
    for (int k = 0; k < n; k++) begin
      if (!pend0 && !pend1) break;
      if (pend0 && pend1) g = RR_EN ? ((last == 0) ? 1 : 0) : 0;
      else g = pend0 ? 0 : 1;
      exp_q.push_back(g);
      last = g;
      if (g == 0 && !p0_hold) pend0 = 1'b0;
    end
    sif.p0_req = 1'b1; sif.p0_addr = a0;
    sif.p1_req = 1'b1; sif.p1_we = 1'b0; sif.p1_addr = a1; sif.p1_be = 2'b11;
    cyc = 0;
    while (got_q.size() < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (sif.p0_ack === 1'b1) begin
        got_q.push_back(0); tb_last = 0;
        check($sformatf("%s_p0_rdata", tag), sif.p0_rdata, ref_rd(int'(a0)));
        last_p0_rd = ref_rd(int'(a0));
        if (!p0_hold) sif.p0_req = 1'b0;
      end
      if (sif.p1_ack === 1'b1) begin
        got_q.push_back(1); tb_last = 1;
        check($sformatf("%s_p1_rdata", tag), sif.p1_rdata, ref_rd(int'(a1)));
      end
      if (got_q.size() >= n) begin
        sif.p0_req = 1'b0; sif.p1_req = 1'b0;
      end
    end
    sif.p0_req = 1'b0; sif.p1_req = 1'b0;
    check($sformatf("%s_grant_count", tag), got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      gv = (k < got_q.size()) ? got_q[k] : -1;
      check($sformatf("%s_grant%0d", tag, k), gv, exp_q[k]);
    end
    @(negedge clk);
  endtask

  initial begin
    int acks_in_rst, port, cyc;
    logic we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0] be;

    sif.p0_req = 1'b0; sif.p0_addr = '0;
    sif.p1_req = 1'b0; sif.p1_we = 1'b0; sif.p1_addr = '0; sif.p1_wdata = '0; sif.p1_be = 2'b00;
    sif.data_from_sram = '0;
    sram_mem[32'h10] = 16'hBEEF;
    ref_mem[32'h10]  = 16'hBEEF;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_strobes", {26'd0, sif.sram_ce_n, sif.sram_oe_n, sif.sram_we_n,
                          sif.sram_ub_n, sif.sram_lb_n, sif.sram_drive}, 32'b111110);
    check("rst_acks", {30'd0, sif.p0_ack, sif.p1_ack}, 0);
    check("rst_p0_rdata", sif.p0_rdata, 0);
    check("rst_p1_rdata", sif.p1_rdata, 0);
    check("rst_addr", sif.sram_addr, 0);
    check("rst_wdata", sif.data_to_sram, 0);
    rst_n = 1'b1;
    tb_last = 1;
    @(negedge clk);

    // Directed accesses.
    access(0, 1'b0, 20'h00010, 16'h0000, 2'b11, "p0_read");
    access(1, 1'b1, 20'h12345, 16'hA55A, 2'b01, "p1_write_lb");
    check("p1_write_lb_mem", sram_rd(32'h12345), 32'h005A);
    both_req(2, 1'b0, 20'h00010, 20'h12345, "tie_once");
    both_req(4, 1'b1, 20'h00010, 20'h12345, "tie_held");
    access(1, 1'b1, 20'h00020, 16'h1234, 2'b11, "raw_write");
    access(1, 1'b0, 20'h00020, 16'h0000, 2'b11, "raw_read");
    check("raw_read_value", sif.p1_rdata, 32'h1234);
    access(1, 1'b1, 20'h00010, 16'h0000, 2'b00, "be00_write");
    check("be00_mem_unchanged", sram_rd(32'h10), 32'hBEEF);
    check("p0_rdata_hold", sif.p0_rdata, last_p0_rd);

    // Reset in the middle of a write pulse.
    sif.p1_req = 1'b1; sif.p1_we = 1'b1; sif.p1_addr = 20'h80000;
    sif.p1_wdata = 16'hFFFF; sif.p1_be = 2'b11;
    cyc = 0;
    while (sif.sram_we_n !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst_reached_pulse", 32'(sif.sram_we_n), 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_strobes", {26'd0, sif.sram_ce_n, sif.sram_oe_n, sif.sram_we_n,
                             sif.sram_ub_n, sif.sram_lb_n, sif.sram_drive}, 32'b111110);
    sif.p1_req = 1'b0;
    acks_in_rst = 0;
    repeat (3) begin
      @(negedge clk);
      if (sif.p0_ack === 1'b1 || sif.p1_ack === 1'b1) acks_in_rst++;
    end
    rst_n = 1'b1;
    tb_last = 1;
    @(negedge clk);
    if (sif.p0_ack === 1'b1 || sif.p1_ack === 1'b1) acks_in_rst++;
    check("midrst_no_ack", acks_in_rst, 0);
    check("midrst_idle_strobes", {31'd0, sif.sram_ce_n}, 1);
    access(0, 1'b0, 20'h00010, 16'h0000, 2'b11, "post_rst_read");

    // Randomized traffic over a small address window so reads hit earlier writes.
    for (int k = 0; k < 24; k++) begin
      port  = int'($urandom_range(0, 1));
      we    = (port == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      addr  = 20'h00100 + 20'($urandom_range(0, 7));
      wdata = 16'($urandom);
      be    = 2'($urandom_range(0, 3));
      access(port, we, addr, wdata, be, $sformatf("rnd%0d", k));
    end

    // Final memory image and bus-rule monitor.
    foreach (ref_mem[a]) begin
      check($sformatf("mem_%0h", a), sram_rd(a), ref_mem[a]);
    end
    check("bus_rules", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sequences the shared off-chip 16-bit asynchronous SRAM and time-shares it between two requesters.
- Port 0 is the VGA line-fetch reader. Port 1 is the game-logic read/write client (trail bitmap updates, collision reads).
- Generates CE/OE/WE/UB/LB strobes, the address, and the tri-state data-drive enable.
- The DQ bus is split into to-SRAM and from-SRAM halves; the top level owns the tri-state buffer.

Parameters:
- ADDR_W, 20, SRAM word address width.
- DATA_W, 16, data width.
- RD_CYC, 2, cycles OE is held low before read data is sampled (>=1).
- WR_CYC, 2, cycles WE is held low (>=1).

Ports:
- Clk in 1: system clock.
- Reset in 1: asynchronous, active-low reset.
- P0_Req in 1: port 0 read request.
- P0_Addr in ADDR_W: port 0 address.
- P0_Ack out 1: one-cycle pulse; P0_RData valid.
- P0_RData out DATA_W: port 0 read data.
- P1_Req in 1: port 1 request.
- P1_We in 1: port 1 write (1) or read (0).
- P1_Addr in ADDR_W: port 1 address.
- P1_WData in DATA_W: port 1 write data.
- P1_BE in 2: port 1 byte enables {UB,LB}; 1 = byte active.
- P1_Ack out 1: one-cycle completion pulse.
- P1_RData out DATA_W: port 1 read data.
- SRAM_ADDR out ADDR_W: SRAM address.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N out 1 each: SRAM strobes, active-low.
- Data_to_SRAM out DATA_W: write data.
- Data_from_SRAM in DATA_W: read data.
- SRAM_Drive out 1: top level drives DQ when 1.

Behaviour:
- Reset (async, Reset=0):
  - State IDLE.
  - All _N strobes = 1; SRAM_Drive = 0; Acks = 0.
  - RData, SRAM_ADDR and Data_to_SRAM = 0.
  - Last-grant = port 1 (port 0 wins the first tie).
- Handshake:
  - Requester holds Req, Addr, We, WData and BE stable until its Ack pulse.
  - Inputs are latched at grant; later changes are ignored until Ack.
  - Req may drop the cycle after Ack or stay high for a back-to-back access.
- Arbitration happens in IDLE only. The default is fixed priority with port 0 first.
- FSM transitions:
  - IDLE: on a grant, latch address/data/BE into registers and go to RD or WR_SETUP.
  - RD: CE_N=0, OE_N=0; port 0 drives UB_N=LB_N=0, port 1 drives from ~BE. Counter runs RD_CYC cycles. On the last cycle, register Data_from_SRAM into the granted port's RData, pulse Ack, go to IDLE.
  - WR_SETUP (1 cycle): CE_N=0, address and Data_to_SRAM valid, SRAM_Drive=1, WE_N=1.
  - WR_PULSE: WE_N=0 for WR_CYC cycles, SRAM_Drive=1, UB_N/LB_N from ~BE.
  - WR_HOLD (1 cycle): WE_N=1, SRAM_Drive=1, data and address held. Pulse P1_Ack, go to IDLE.
- Latency from grant to Ack:
  - Read: RD_CYC+1 cycles.
  - Write: WR_CYC+3 cycles.
- Bus and strobe rules:
  - SRAM_Drive is never 1 while OE_N=0.
  - OE_N and WE_N are never both 0.
  - All strobes are registered outputs (glitch-free).
  - Address is stable for the full access.
- RData holds its last value between accesses.
- P1_BE=00 with write: the full cycle runs with both byte strobes high, and Ack still pulses.
- Reset mid-access: strobes deassert immediately and the access is aborted with no Ack. The requester must reissue.

Optional Feature:
- SRAM_ARB_RR_EN defined: round-robin. When both requesters are pending in IDLE, the port not granted last wins. This prevents the game from starving during active video.
- Undefined: strict port-0 priority. The last-grant register is removed.

Decomposition:
- Package sram_arb_pkg holds:
  - the state enum typedef (IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD);
  - the port-select typedef;
  - default timing constants.
- One sub-module, sram_arb_timer: a loadable down-counter with a done flag, used for the RD and WR_PULSE dwell.

Test Plan:
- P0 read: P0_Addr=0x00010, SRAM model returns 0xBEEF. Expect OE_N low 2 cycles, P0_Ack at grant+3, P0_RData=0xBEEF, SRAM_Drive stays 0.
- P1 write: Addr=0x12345, WData=0xA55A, BE=01. Expect LB_N=0, UB_N=1, WE_N low exactly 2 cycles with SRAM_Drive=1 one cycle before and after, P1_Ack at grant+5. Model shows only the low byte written (0x5A).
- Both Req high in the same cycle, default build: port 0 served first, then port 1. With SRAM_ARB_RR_EN and both held high for 4 accesses: grants alternate 0,1,0,1.
- Back-to-back P1 read-after-write to the same address 0x00020, data 0x1234: the read returns 0x1234. IDLE separates the accesses, with OE_N and WE_N never both low.
- Reset asserted during WR_PULSE: all strobes go to 1 and SRAM_Drive to 0 within the same cycle (async), no Ack. After release, the FSM is in IDLE and a new P0 read completes normally.
- P1 write with BE=00: full write timing runs, UB_N=LB_N=1 throughout, P1_Ack pulses, SRAM contents unchanged.
